// File: rtl/skew_rf_pkg.sv
// rtl/skew_rf_pkg.sv - shared types, defaults and width helper for the skewed operand register file
package skew_rf_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_N     = 8;
  localparam int DEF_DEPTH = 8;

  typedef logic [DEF_DW-1:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Bits needed for the step counter; steps run 0 .. DEPTH+N-2.
  function automatic int step_width(input int depth, input int n);
    return (depth + n - 1 > 1) ? $clog2(depth + n - 1) : 1;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - one lane of storage with write decode, skew offset compare and registered output
module skew_lane
  import skew_rf_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANE  = 0,
  parameter int SW    = 4,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_row_i,
  input  logic [DW-1:0] din_i,
  input  logic          load_i,
  input  logic [SW-1:0] step_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic [SW:0]   off;
  logic          hit;
  logic          row_ok;

  // Entry index for this lane is step minus lane number; the extra top bit is the borrow.
  assign off    = {1'b0, step_i} - (SW+1)'(LANE);
  assign hit    = load_i && !off[SW] && (off < (SW+1)'(DEPTH));
  assign row_ok = {1'b0, wr_row_i} < (AW+1)'(DEPTH);

`ifdef RF_RST_CLR_EN
  // Storage write port; reset wipes every entry.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (wr_en_i && row_ok) begin
      mem_q[wr_row_i] <= din_i;
    end
  end
`else
  // Storage write port; contents survive reset so the array can map to LUTRAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && row_ok) mem_q[wr_row_i] <= din_i;
  end
`endif

  // Present the entry for the current step, or a zero bubble outside this lane's window.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (hit) begin
      data_q  <= mem_q[off[AW-1:0]];
      valid_q <= 1'b1;
    end else begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/skew_rf.sv
// rtl/skew_rf.sv - X/W operand register file streaming diagonally skewed lanes; RF_RST_CLR_EN also clears storage on reset
module skew_rf
  import skew_rf_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_row_i,
  input  logic [N*DW-1:0] x_din_i,
  input  logic [N*DW-1:0] w_din_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [N*DW-1:0] x_out_o,
  output logic [N*DW-1:0] w_out_o,
  output logic [N-1:0]    valid_o
);

  localparam int            SW   = step_width(DEPTH, N);
  localparam logic [SW-1:0] LAST = SW'(DEPTH + N - 2);

  state_t        state_q;
  logic [SW-1:0] step_q;
  logic          busy_q;
  logic          done_q;
  logic          wr_go;
  logic          load;
  logic [N-1:0]  x_valid;
  logic [N-1:0]  w_valid;

  assign wr_go = rst_n_i && wr_en_i && (state_q == IDLE);
  assign load  = (state_q == STREAM);

  // Sequencer: walk steps 0..LAST once per START, flag BUSY/DONE alongside the lane outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= STREAM;
            step_q  <= '0;
          end
        end
        STREAM: begin
          busy_q <= 1'b1;
          done_q <= (step_q == LAST);
          if (step_q == LAST) begin
            state_q <= IDLE;
            step_q  <= '0;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(.DW(DW), .DEPTH(DEPTH), .LANE(i), .SW(SW), .AW(AW)) u_x (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .wr_en_i (wr_go),
      .wr_row_i(wr_row_i),
      .din_i   (x_din_i[i*DW +: DW]),
      .load_i  (load),
      .step_i  (step_q),
      .data_o  (x_out_o[i*DW +: DW]),
      .valid_o (x_valid[i])
    );
    skew_lane #(.DW(DW), .DEPTH(DEPTH), .LANE(i), .SW(SW), .AW(AW)) u_w (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .wr_en_i (wr_go),
      .wr_row_i(wr_row_i),
      .din_i   (w_din_i[i*DW +: DW]),
      .load_i  (load),
      .step_i  (step_q),
      .data_o  (w_out_o[i*DW +: DW]),
      .valid_o (w_valid[i])
    );
  end

  assign valid_o = x_valid & w_valid;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: doc/skew_rf.md
# skew_rf

Parametrised operand register file for the systolic array. It stores an X matrix and a pre-transposed W matrix as N lanes × DEPTH entries each. On START it streams both matrices into the array edge with automatic diagonal skew: lane i runs i cycles behind lane 0. A per-lane valid flag and zero-filled bubbles replace the external index arithmetic used by the previous generation.

## Interface
- DW, 16, operand word width in bits
- N, 8, lanes per matrix (array rows/columns)
- DEPTH, 8, entries per lane (reduction length K)
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- WR_EN  in  1  write one row into both matrices
- WR_ROW  in  $clog2(DEPTH)  entry index for the write
- X_DIN  in  N×DW  packed, lane i at bits [i*DW +: DW]
- W_DIN  in  N×DW  packed, same layout
- START  in  1  begin a stream (accepted in IDLE only)
- BUSY  out  1  high while streaming
- DONE  out  1  one-cycle pulse with the last valid beat
- X_OUT  out  N×DW  skewed X operands
- W_OUT  out  N×DW  skewed W operands
- VALID  out  N  per-lane operand valid

## Operation
- Storage: X_mem[i][k] and W_mem[i][k], with i < N and k < DEPTH.
- Write: when WR_EN is high in IDLE, lane i of X_DIN goes to X_mem[i][WR_ROW], and lane i of W_DIN goes to W_mem[i][WR_ROW].
  - WR_EN during STREAM is ignored.
  - WR_ROW ≥ DEPTH (non-power-of-2 DEPTH) is ignored.
- FSM has two states, IDLE and STREAM.
  - IDLE→STREAM when START is high; step counter t is cleared to 0.
  - STREAM→IDLE after step t = DEPTH+N−2 has been loaded.
  - START while in STREAM is ignored.
- Step t:
  - If 0 ≤ t−i < DEPTH, lane i loads X_mem[i][t−i] and W_mem[i][t−i], with VALID[i]=1.
  - Otherwise lane i loads 0, with VALID[i]=0.
- Counter width is $clog2(DEPTH+N−1). The t−i comparison is done unsigned with a borrow check; there is no wrap-around.
- WR_EN and START in the same IDLE cycle: the write commits at that edge, and the stream sees the updated data.
- In IDLE all X_OUT, W_OUT and VALID are 0.

## Timing
- All outputs are registered.
- Reset values: BUSY=0, DONE=0, VALID=0, X_OUT=0, W_OUT=0. State resets to IDLE and t to 0.
- START is sampled at edge E0. The outputs for step t appear after edge E(t+1), so lane 0 entry 0 is visible one cycle after START.
- BUSY is high from E0 through edge E(DEPTH+N−1). That is DEPTH+N−1 output cycles.
- DONE is high for exactly the cycle in which step DEPTH+N−2 is presented, i.e. lane N−1 entry DEPTH−1. BUSY is high in that same cycle.
- The edge after DONE returns all outputs to 0. START is accepted again at that edge.
- Back-to-back streams therefore have exactly one idle output cycle between them.
- RST_N low mid-stream: at that edge the block goes to IDLE and all outputs clear. No DONE is issued.
- Write latency: data written at edge E is readable by a stream started at E or later.

## Configuration
- RF_RST_CLR_EN defined: reset also zeroes all 2×N×DEPTH storage words.
- RF_RST_CLR_EN undefined: storage is not reset (inferrable as LUTRAM) and retains its contents across RST_N. Only control and output registers reset.

## Structure
- Package skew_rf_pkg holds:
  - the state enum (IDLE, STREAM);
  - the default DW, N and DEPTH;
  - typedef word_t as logic [DW−1:0];
  - the function step_width returning $clog2(DEPTH+N−1).
- Sub-module skew_lane, instantiated 2N times:
  - contents: one lane's DEPTH-entry storage, the write decode, the offset comparison against a LANE parameter, and the registered output/valid;
  - the top level owns the FSM, counter, BUSY and DONE.

## Test plan
Use N=8, DEPTH=8, DW=16.
- Reset: hold RST_N low for 2 cycles with random inputs → all outputs 0 and BUSY=0.
- Load and stream:
  - stimulus: write X_mem[i][k]=16'h0100·i+k and W=16'h8000|(i<<4|k), then START;
  - response: one cycle later only VALID[0]=1 with X_OUT[0]=0x0000;
  - at stream cycle 7, VALID=8'hFF and X_OUT[7]=0x0700;
  - at cycle 14, only VALID[7]=1, X_OUT[7]=0x0707 and DONE=1;
  - BUSY is high for 15 cycles.
- Ignored inputs: assert START and WR_EN (row 3, data 0xFFFF) at stream cycle 5 → the stream completes unchanged and memory row 3 is unmodified on the next stream.
- Simultaneous write and start: WR_EN to row 0 with X lane 0 = 0xABCD together with START → the first beat shows X_OUT[0]=0xABCD.
- Reset mid-stream: drop RST_N at stream cycle 6 → the next cycle has all outputs 0 and no DONE.
  - With RF_RST_CLR_EN: a new stream outputs all zeros with VALID set.
  - Without it: a new stream outputs the original data.
- Back-to-back: assert START on the DONE cycle's next edge → exactly one idle cycle separates the two streams, and the second stream is identical to the first.
